// File: rtl/s2mm_frame_ctrl.sv
// s2mm_frame_ctrl: sequences S2MM frame captures (flush, DataMover command, status) with ping-pong buffers.
// Optional watchdog on CAPTURE/STATUS: define S2MM_TIMEOUT_EN.
module s2mm_frame_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int BTT_W   = 23,
    parameter int RST_CYC = 8
`ifdef S2MM_TIMEOUT_EN
    , parameter int TMO_CYC = 2**26
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_continuous,
    input  logic [31:0]       cfg_frame_bytes,
    input  logic [ADDR_W-1:0] cfg_addr0,
    input  logic [ADDR_W-1:0] cfg_addr1,
    output logic              new_frame,
    output logic [31:0]       expBytes,
    input  logic [31:0]       dataCnt,
    input  logic              FIFO_overflow,
    input  logic              axis_last_hs,
    output logic [71:0]       cmd_tdata,
    output logic              cmd_tvalid,
    input  logic              cmd_tready,
    input  logic [7:0]        sts_tdata,
    input  logic              sts_tvalid,
    output logic              sts_tready,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              buf_sel,
    output logic              err_cfg,
    output logic              err_ovf,
    output logic              err_dma,
    output logic              err_tmo
);
    localparam logic [2:0] IDLE = 3'd0, FLUSH = 3'd1, ISSUE = 3'd2, CAPTURE = 3'd3, STATUS = 3'd4, ERROR = 3'd5;
    localparam int FC_W = $clog2(RST_CYC);

    logic [2:0]        state;
    logic [FC_W-1:0]   flush_cnt;
    logic [ADDR_W-1:0] addr0_q, addr1_q, cur_addr;
    logic              stop_pending;
    logic              ovf_s1, ovf_s2, ovf_s3;
    logic              sts_buf_vld, sts_buf_ok;
    logic              cfg_bad, ovf_err, sts_avail, sts_ok, tmo_hit;
    logic              unused_sts;

    assign unused_sts = ^sts_tdata[6:0];
    assign busy       = state != IDLE && state != ERROR;
    assign new_frame  = state == FLUSH || state == ERROR;
    assign cmd_tvalid = state == ISSUE;
    // A status word may beat axis_last_hs; hold one in CAPTURE and stop accepting until it is consumed.
    assign sts_tready = state == ERROR || ((state == CAPTURE || state == STATUS) && !sts_buf_vld);
    assign cur_addr   = buf_sel ? addr1_q : addr0_q;
    assign cmd_tdata  = cmd_tvalid ? {4'h0, frame_cnt[3:0], 32'(cur_addr), 1'b0, 1'b1, 6'h0, 1'b1, expBytes[22:0]} : '0;
    assign cfg_bad    = cfg_frame_bytes == 32'd0 || |cfg_frame_bytes[1:0] || {1'b0, cfg_frame_bytes} >= (33'd1 << BTT_W);
    assign ovf_err    = (busy && ovf_s2 && !ovf_s3) || (state == CAPTURE && dataCnt > expBytes);
    assign sts_avail  = sts_buf_vld || sts_tvalid;
    assign sts_ok     = sts_buf_vld ? sts_buf_ok : sts_tdata[7];

`ifdef S2MM_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    always_ff @(posedge sys_clk) begin
        if (sys_rst || (state == ISSUE && cmd_tready))
            tmo_cnt <= '0;
        else if (state == CAPTURE || state == STATUS)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
    assign tmo_hit = (state == CAPTURE || state == STATUS) && tmo_cnt == TW'(TMO_CYC - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            flush_cnt    <= '0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            stop_pending <= 1'b0;
            {ovf_s1, ovf_s2, ovf_s3} <= '0;
            sts_buf_vld  <= 1'b0;
            sts_buf_ok   <= 1'b0;
            expBytes     <= '0;
            frame_cnt    <= '0;
            buf_sel      <= 1'b0;
            frame_done   <= 1'b0;
            {err_cfg, err_ovf, err_dma, err_tmo} <= '0;
        end else begin
            {ovf_s1, ovf_s2, ovf_s3} <= {FIFO_overflow, ovf_s1, ovf_s2};
            frame_done <= 1'b0;
            if (busy)
                stop_pending <= stop_pending | ctrl_stop;
            if (ovf_err || tmo_hit) begin
                if (ovf_err)
                    err_ovf <= 1'b1;
                if (tmo_hit)
                    err_tmo <= 1'b1;
                sts_buf_vld <= 1'b0;
                state       <= ERROR;
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        sts_buf_vld <= 1'b0;
                        if (ctrl_start && cfg_bad) begin
                            err_cfg      <= 1'b1;
                            stop_pending <= 1'b0;
                            state        <= IDLE;
                        end else if (ctrl_start) begin
                            addr0_q      <= cfg_addr0;
                            addr1_q      <= cfg_addr1;
                            expBytes     <= cfg_frame_bytes;
                            frame_cnt    <= '0;
                            buf_sel      <= 1'b0;
                            flush_cnt    <= '0;
                            stop_pending <= ctrl_stop;
                            {err_cfg, err_ovf, err_dma, err_tmo} <= '0;
                            state        <= FLUSH;
                        end else if (state == IDLE) begin
                            stop_pending <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        flush_cnt <= flush_cnt + 1'b1;
                        if (flush_cnt == FC_W'(RST_CYC - 1))
                            state <= ISSUE;
                    end
                    // An accepted command cannot be withdrawn, so the handshake outranks a stop.
                    ISSUE: state <= cmd_tready ? CAPTURE : ctrl_stop ? IDLE : ISSUE;
                    CAPTURE: begin
                        if (sts_tvalid && !sts_buf_vld) begin
                            sts_buf_vld <= 1'b1;
                            sts_buf_ok  <= sts_tdata[7];
                        end
                        if (axis_last_hs)
                            state <= STATUS;
                    end
                    STATUS: begin
                        if (sts_avail) begin
                            sts_buf_vld <= 1'b0;
                            if (!sts_ok) begin
                                err_dma <= 1'b1;
                                state   <= ERROR;
                            end else begin
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 1'b1;
                                if (stop_pending || ctrl_stop || !ctrl_continuous) begin
                                    state <= IDLE;
                                end else begin
                                    buf_sel   <= ~buf_sel;
                                    flush_cnt <= '0;
                                    state     <= FLUSH;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_s2mm_frame_ctrl.sv
// tb_s2mm_frame_ctrl: directed bench with a command scoreboard for s2mm_frame_ctrl.
module tb_s2mm_frame_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst, ctrl_start, ctrl_stop, ctrl_continuous;
    logic [31:0] cfg_frame_bytes, cfg_addr0, cfg_addr1, expBytes, dataCnt;
    logic        new_frame, FIFO_overflow, axis_last_hs;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid, cmd_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tvalid, sts_tready, busy, frame_done, buf_sel;
    logic [15:0] frame_cnt;
    logic        err_cfg, err_ovf, err_dma, err_tmo;

    int tests = 0, fails = 0, cmd_cnt = 0, done_cnt = 0, nf_run = 0, nf_len = 0;
    logic [71:0] exp_q[$];

    localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000;

    always #5 sys_clk = ~sys_clk;

    s2mm_frame_ctrl #(
        .RST_CYC(8)
`ifdef S2MM_TIMEOUT_EN
        , .TMO_CYC(100)
`endif
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
        .ctrl_continuous(ctrl_continuous), .cfg_frame_bytes(cfg_frame_bytes), .cfg_addr0(cfg_addr0),
        .cfg_addr1(cfg_addr1), .new_frame(new_frame), .expBytes(expBytes), .dataCnt(dataCnt),
        .FIFO_overflow(FIFO_overflow), .axis_last_hs(axis_last_hs), .cmd_tdata(cmd_tdata),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .sts_tdata(sts_tdata), .sts_tvalid(sts_tvalid),
        .sts_tready(sts_tready), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .buf_sel(buf_sel), .err_cfg(err_cfg), .err_ovf(err_ovf), .err_dma(err_dma), .err_tmo(err_tmo)
    );

    function automatic logic [71:0] mk_cmd(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
        return {4'h0, tag, a, 1'b0, 1'b1, 6'h00, 1'b1, b[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        ctrl_start = 1'b1;
        step();
        ctrl_start = 1'b0;
    endtask

    task automatic wait_cmd();
        int c0 = cmd_cnt;
        int n = 0;
        while (cmd_cnt == c0 && n < 60) begin
            step();
            n++;
        end
        chk("cmd_arrived", 72'(cmd_cnt != c0), 72'(1));
    endtask

    task automatic finish_frame(input logic [7:0] sts, input bit early);
        sts_tdata = sts;
        if (early) begin
            sts_tvalid = 1'b1;
            step();
            sts_tvalid = 1'b0;
            step(2);
            axis_last_hs = 1'b1;
            step();
            axis_last_hs = 1'b0;
        end else begin
            axis_last_hs = 1'b1;
            step();
            axis_last_hs = 1'b0;
            sts_tvalid = 1'b1;
            step();
            sts_tvalid = 1'b0;
        end
        step(2);
    endtask

    // Scoreboard pop on every command handshake; also track done pulses and new_frame run length.
    always @(negedge sys_clk) begin
        if (!sys_rst && cmd_tvalid && cmd_tready) begin
            cmd_cnt++;
            if (exp_q.size() == 0)
                chk("cmd_unexpected", cmd_tdata, 72'(0));
            else
                chk("cmd", cmd_tdata, exp_q.pop_front());
        end
        if (frame_done)
            done_cnt++;
        if (new_frame)
            nf_run++;
        else if (nf_run != 0) begin
            nf_len = nf_run;
            nf_run = 0;
        end
    end

    initial begin
        int c, d, n;
        sys_rst = 1'b1; ctrl_start = 0; ctrl_stop = 0; ctrl_continuous = 0;
        cfg_frame_bytes = 32'd4096; cfg_addr0 = A0; cfg_addr1 = A1; dataCnt = 0;
        FIFO_overflow = 0; axis_last_hs = 0; cmd_tready = 0; sts_tdata = 0; sts_tvalid = 0;
        step(3);
        chk("rst_new_frame", new_frame, 0);
        chk("rst_cmd_tvalid", cmd_tvalid, 0);
        chk("rst_sts_tready", sts_tready, 0);
        chk("rst_expBytes", expBytes, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_tdata", cmd_tdata, 0);
        sys_rst = 1'b0;
        step();

        // single 4096-byte frame
        cmd_tready = 1'b1;
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h1000));
        pulse_start();
        chk("single_busy", busy, 1);
        chk("single_expBytes", expBytes, 32'd4096);
        chk("single_new_frame", new_frame, 1);
        wait_cmd();
        finish_frame(8'h80, 1'b0);
        chk("single_nf_len", nf_len, 8);
        chk("single_done", done_cnt, 1);
        chk("single_frame_cnt", frame_cnt, 1);
        chk("single_idle", busy, 0);

        // continuous, stop during third frame
        ctrl_continuous = 1'b1;
        cfg_frame_bytes = 32'h2000;
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h2000));
        exp_q.push_back(mk_cmd(4'd1, A1, 32'h2000));
        exp_q.push_back(mk_cmd(4'd2, A0, 32'h2000));
        d = done_cnt;
        pulse_start();
        wait_cmd();
        finish_frame(8'h80, 1'b0);
        wait_cmd();
        finish_frame(8'h81, 1'b0);
        chk("cont_buf_sel", buf_sel, 0);
        chk("cont_busy_f3", busy, 1);
        ctrl_stop = 1'b1;
        step();
        ctrl_stop = 1'b0;
        wait_cmd();
        finish_frame(8'h82, 1'b0);
        c = cmd_cnt;
        step(20);
        chk("cont_frame_cnt", frame_cnt, 3);
        chk("cont_done", done_cnt - d, 3);
        chk("cont_idle", busy, 0);
        chk("cont_no_more_cmd", cmd_cnt, c);
        ctrl_continuous = 1'b0;

        // config errors
        c = cmd_cnt;
        cfg_frame_bytes = 32'h1002;
        pulse_start();
        chk("cfg_unaligned_err", err_cfg, 1);
        step(3);
        chk("cfg_no_new_frame", new_frame, 0);
        chk("cfg_busy", busy, 0);
        chk("cfg_no_cmd", cmd_cnt, c);
        cfg_frame_bytes = 32'h0080_0000;
        pulse_start();
        chk("cfg_too_big_busy", busy, 0);
        cfg_frame_bytes = 32'h007F_FFFC;
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h007F_FFFC));
        pulse_start();
        chk("cfg_max_ok_busy", busy, 1);
        chk("cfg_cleared", err_cfg, 0);
        wait_cmd();
        finish_frame(8'h80, 1'b0);
        cfg_frame_bytes = 32'd0;
        pulse_start();
        chk("cfg_zero_err", err_cfg, 1);

        // overflow from rx domain during CAPTURE
        cfg_frame_bytes = 32'd4096;
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h1000));
        pulse_start();
        wait_cmd();
        FIFO_overflow = 1'b1;
        n = 0;
        while (!err_ovf && n < 6) begin
            step();
            n++;
        end
        chk("ovf_latency_le4", 72'(n <= 4), 72'(1));
        chk("ovf_err", err_ovf, 1);
        chk("ovf_busy", busy, 0);
        chk("ovf_new_frame_held", new_frame, 1);
        chk("ovf_sts_drain", sts_tready, 1);
        chk("ovf_cmd_tvalid", cmd_tvalid, 0);
        FIFO_overflow = 1'b0;
        step(4);

        // dataCnt beyond expected bytes
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h1000));
        pulse_start();
        chk("restart_from_error", err_ovf, 0);
        wait_cmd();
        dataCnt = 32'd4100;
        step();
        chk("datacnt_ovf", err_ovf, 1);
        chk("datacnt_busy", busy, 0);
        dataCnt = 32'd0;

        // SLVERR status
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h1000));
        pulse_start();
        d = done_cnt;
        wait_cmd();
        finish_frame(8'h40, 1'b0);
        chk("dma_err", err_dma, 1);
        chk("dma_frame_cnt", frame_cnt, 0);
        chk("dma_no_done", done_cnt, d);
        chk("dma_busy", busy, 0);

        // status before axis_last_hs
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h1000));
        pulse_start();
        chk("early_err_dma_clr", err_dma, 0);
        d = done_cnt;
        wait_cmd();
        finish_frame(8'h80, 1'b1);
        step(5);
        chk("early_done_once", done_cnt - d, 1);
        chk("early_frame_cnt", frame_cnt, 1);
        chk("early_idle", busy, 0);

        // stop while command pending
        cmd_tready = 1'b0;
        pulse_start();
        step(12);
        chk("abort_in_issue", cmd_tvalid, 1);
        ctrl_stop = 1'b1;
        step();
        ctrl_stop = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_cmd_tvalid", cmd_tvalid, 0);

        // reset mid-ISSUE
        pulse_start();
        step(12);
        sys_rst = 1'b1;
        step();
        chk("midrst_cmd_tvalid", cmd_tvalid, 0);
        chk("midrst_cmd_tdata", cmd_tdata, 0);
        chk("midrst_new_frame", new_frame, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_expBytes", expBytes, 0);
        sys_rst = 1'b0;
        step();

`ifdef S2MM_TIMEOUT_EN
        cmd_tready = 1'b1;
        exp_q.push_back(mk_cmd(4'd0, A0, 32'h1000));
        pulse_start();
        wait_cmd();
        n = 0;
        while (!err_tmo && n < 200) begin
            step();
            n++;
        end
        chk("tmo_cycles", n, 100);
        chk("tmo_busy", busy, 0);
`else
        chk("tmo_tied_low", err_tmo, 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
